// File: rtl/even_parity_frame_rx.sv
// Serial frame receiver for the even parity checker.
// Frame on sin: start(0), DATA_W data bits LSB first, parity bit, stop(1).
// The received word and parity bit are presented in parallel under a
// valid/ready handshake. Parity is not evaluated here; the downstream
// checker does that.
module even_parity_frame_rx #(
  parameter int unsigned DATA_W = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              sin,
  input  logic              bit_en,
  output logic [DATA_W-1:0] o_data,
  output logic              o_pb,
  output logic              o_valid,
  input  logic              o_ready,
  output logic              frame_err,
  output logic              overrun,
  output logic              busy
);

  // One extra bit keeps the counter legal when DATA_W = 1.
  localparam int unsigned CW = $clog2(DATA_W) + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DATA_W - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic              sin_m, sin_s;
  logic [CW-1:0]     cnt_q;
  logic [DATA_W-1:0] sr_q;
  logic              pb_r;

  // Decoded strobes for the stop-bit sample
  logic stop_smp, frame_ok, slot_free, load, drop_ovr, bad_stop;

  // Two-flop synchronizer; idle-high line so both flops reset to 1
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sin_m <= 1'b1;
      sin_s <= 1'b1;
    end else begin
      sin_m <= sin;
      sin_s <= sin_m;
    end
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // FSM next-state logic; advances only on bit strobes
  always_comb begin
    state_d = state_q;
    if (bit_en) begin
      case (state_q)
        IDLE:    if (!sin_s) state_d = DATA;
        DATA:    if (cnt_q == CNT_LAST) state_d = PARITY;
        PARITY:  state_d = STOP;
        STOP:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // FSM output decode: busy flag and stop-bit outcome strobes
  always_comb begin
    busy      = (state_q != IDLE);
    stop_smp  = bit_en && (state_q == STOP);
    frame_ok  = stop_smp && sin_s;
    bad_stop  = stop_smp && !sin_s;
    // A slot being accepted on this same edge counts as free.
    slot_free = !o_valid || o_ready;
    load      = frame_ok && slot_free;
    drop_ovr  = frame_ok && !slot_free;
  end

  // Shift register, bit counter and captured parity bit
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      sr_q  <= '0;
      pb_r  <= 1'b0;
    end else if (bit_en) begin
      case (state_q)
        IDLE: if (!sin_s) cnt_q <= '0;
        DATA: begin
          for (int unsigned k = 0; k < DATA_W; k++) begin
            if (cnt_q == CW'(k)) sr_q[k] <= sin_s;
          end
          if (cnt_q != CNT_LAST) cnt_q <= cnt_q + CW'(1);
        end
        PARITY:  pb_r <= sin_s;
        default: ;
      endcase
    end
  end

  // Output slot, handshake and error pulses
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_data    <= '0;
      o_pb      <= 1'b0;
      o_valid   <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      frame_err <= bad_stop;
      overrun   <= drop_ovr;
      if (load) begin
        o_data  <= sr_q;
        o_pb    <= pb_r;
        o_valid <= 1'b1;
      end else if (o_valid && o_ready) begin
        o_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_even_parity_frame_rx.sv
// Directed bench for even_parity_frame_rx (DATA_W = 3).
module tb_even_parity_frame_rx;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       sin;
  logic       bit_en;
  logic [2:0] o_data;
  logic       o_pb;
  logic       o_valid;
  logic       o_ready;
  logic       frame_err;
  logic       overrun;
  logic       busy;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  // Pulse monitors
  int unsigned fe_cnt = 0, ov_cnt = 0, fe_wide = 0, ov_wide = 0;
  logic        fe_prev = 1'b0, ov_prev = 1'b0;
  logic [2:0]  ov_data = '0;

  even_parity_frame_rx #(.DATA_W(3)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .sin       (sin),
    .bit_en    (bit_en),
    .o_data    (o_data),
    .o_pb      (o_pb),
    .o_valid   (o_valid),
    .o_ready   (o_ready),
    .frame_err (frame_err),
    .overrun   (overrun),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (frame_err) fe_cnt++;
    if (overrun) begin
      ov_cnt++;
      ov_data = o_data;
    end
    if (frame_err && fe_prev) fe_wide++;
    if (overrun && ov_prev) ov_wide++;
    fe_prev = frame_err;
    ov_prev = overrun;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // One line bit held for per cycles; strobe in the last cycle of the window
  task automatic send_bit(input logic b, input int unsigned per);
    sin = b;
    for (int unsigned c = 0; c < per; c++) begin
      bit_en = (c == per - 1);
      @(posedge clk);
      #1;
    end
  endtask

  // bits[0] goes on the line first (start), bits[5] last (stop)
  task automatic send_frame(input logic [5:0] bits, input int unsigned per);
    for (int unsigned k = 0; k < 6; k++) send_bit(bits[k], per);
  endtask

  task automatic wait_valid(output int unsigned n);
    n = 0;
    while (!o_valid && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
  endtask

  task automatic accept();
    o_ready = 1'b1;
    tick(1);
    o_ready = 1'b0;
  endtask

  int unsigned lat;
  int unsigned fe0, ov0;

  initial begin
    rst_n = 1'b0; sin = 1'b1; bit_en = 1'b1; o_ready = 1'b0;

    // 1: reset with sin toggling
    for (int i = 0; i < 4; i++) begin
      sin = ~sin;
      tick(1);
    end
    check("rst_valid", 32'(o_valid), 32'd0);
    check("rst_data", 32'(o_data), 32'd0);
    check("rst_pb", 32'(o_pb), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_ferr", 32'(frame_err), 32'd0);
    check("rst_ovr", 32'(overrun), 32'd0);
    sin = 1'b1;
    rst_n = 1'b1;
    tick(5);
    check("idle_busy", 32'(busy), 32'd0);
    check("idle_valid", 32'(o_valid), 32'd0);

    // 2: good frame 0,1,0,1,0,1
    send_frame(6'b101010, 1);
    wait_valid(lat);
    check("good_latency", lat, 32'd2);
    check("good_valid", 32'(o_valid), 32'd1);
    check("good_data", 32'(o_data), 32'h5);
    check("good_pb", 32'(o_pb), 32'd0);
    check("good_cp", 32'(^{o_data, o_pb}), 32'd0);
    tick(3);
    check("good_hold", 32'(o_valid), 32'd1);
    accept();
    check("good_accept", 32'(o_valid), 32'd0);

    // 3: parity error passthrough 0,1,1,0,1,1
    send_frame(6'b110110, 1);
    wait_valid(lat);
    check("perr_valid", 32'(o_valid), 32'd1);
    check("perr_data", 32'(o_data), 32'h3);
    check("perr_pb", 32'(o_pb), 32'd1);
    check("perr_cp", 32'(^{o_data, o_pb}), 32'd1);
    accept();

    // 4: framing error 0,1,1,1,0,0
    fe0 = fe_cnt;
    send_frame(6'b001110, 1);
    sin = 1'b1;
    tick(5);
    check("ferr_count", fe_cnt - fe0, 32'd1);
    check("ferr_valid", 32'(o_valid), 32'd0);
    check("ferr_no_ovr", ov_cnt, 32'd0);
    check("ferr_busy", 32'(busy), 32'd0);

    // 5: overrun, then reload on stop edge with o_ready=1
    send_frame(6'b101010, 1);
    wait_valid(lat);
    check("ovr_first", 32'(o_data), 32'h5);
    fe0 = fe_cnt;
    ov0 = ov_cnt;
    send_frame(6'b101100, 1);
    tick(5);
    check("ovr_count", ov_cnt - ov0, 32'd1);
    check("ovr_data_at_pulse", 32'(ov_data), 32'h5);
    check("ovr_data_held", 32'(o_data), 32'h5);
    check("ovr_valid", 32'(o_valid), 32'd1);
    check("ovr_no_ferr", fe_cnt - fe0, 32'd0);
    ov0 = ov_cnt;
    send_frame(6'b101100, 1);
    tick(1);
    o_ready = 1'b1;
    tick(1);
    o_ready = 1'b0;
    check("reload_valid", 32'(o_valid), 32'd1);
    check("reload_data", 32'(o_data), 32'h6);
    check("reload_pb", 32'(o_pb), 32'd0);
    tick(3);
    check("reload_no_ovr", ov_cnt - ov0, 32'd0);
    accept();
    check("reload_accept", 32'(o_valid), 32'd0);

    // 6: slow strobe, reset mid-frame, then frame 3'b010
    bit_en = 1'b0;
    tick(2);
    send_bit(1'b0, 4);
    send_bit(1'b0, 4);
    send_bit(1'b1, 4);
    bit_en = 1'b0;
    check("mid_busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_busy", 32'(busy), 32'd0);
    sin = 1'b1;
    tick(2);
    rst_n = 1'b1;
    send_bit(1'b1, 4);
    send_bit(1'b1, 4);
    check("post_rst_valid", 32'(o_valid), 32'd0);
    send_frame(6'b110100, 4);
    bit_en = 1'b0;
    check("slow_valid", 32'(o_valid), 32'd1);
    check("slow_data", 32'(o_data), 32'h2);
    check("slow_pb", 32'(o_pb), 32'd1);
    accept();

    check("ferr_width", fe_wide, 32'd0);
    check("ovr_width", ov_wide, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
